// File: rtl/normalizer.sv
// normalizer: finds the shift count that left- or right-justifies a 16-bit operand,
// resolving one barrel stage (8, 4, 2, 1) per cycle by binary search.
module normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] In,
    input  logic        Dir,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Out,
    output logic [3:0]  Cnt,
    output logic        Zero
);
    typedef enum logic [2:0] {IDLE, S8, S4, S2, S1} state_t;
    state_t      state_q, state_d;
    logic [15:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d, zero_q, zero_d, done_q, done_d;
    logic [3:0]  k;
    logic [15:0] hi_mask, lo_mask, shifted;
    logic        fire, accept, step;
    always_comb begin
        // k is both the stage shift amount and its one-hot count bit
        k       = state_q == S8 ? 4'd8 : state_q == S4 ? 4'd4 : state_q == S2 ? 4'd2 : 4'd1;
        hi_mask = ~(16'hFFFF >> k);
        lo_mask = ~(16'hFFFF << k);
        fire    = (work_q & (dir_q ? lo_mask : hi_mask)) == 16'h0;
        shifted = dir_q ? work_q >> k : work_q << k;
        accept  = state_q == IDLE && Start;
        step    = state_q != IDLE && fire;
        state_d = state_q == IDLE ? (Start ? S8 : IDLE) :
                  state_q == S8   ? S4 :
                  state_q == S4   ? S2 :
                  state_q == S2   ? S1 : IDLE;
        work_d  = accept ? In : step ? shifted : work_q;
        cnt_d   = accept ? 4'd0 : step ? cnt_q | k : cnt_q;
        dir_d   = accept ? Dir : dir_q;
        zero_d  = accept ? In == 16'h0 : zero_q;
        done_d  = state_q == S1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= 16'h0;
            cnt_q   <= 4'd0;
            dir_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end
    assign Busy = state_q != IDLE;
    assign Done = done_q;
    assign Out  = work_q;
    assign Cnt  = cnt_q;
    assign Zero = zero_q;
endmodule

// File: tb/tb_normalizer.sv
// tb_normalizer: directed and swept checks of the multi-cycle normalizer.
module tb_normalizer;
    logic        clk = 1'b0, rst = 1'b1, Start = 1'b0, Dir = 1'b0;
    logic [15:0] In = 16'h0;
    logic        Busy, Done, Zero;
    logic [15:0] Out;
    logic [3:0]  Cnt;
    int vectors = 0, miscompares = 0;

    normalizer dut (.clk(clk), .rst(rst), .Start(Start), .In(In), .Dir(Dir),
                    .Busy(Busy), .Done(Done), .Out(Out), .Cnt(Cnt), .Zero(Zero));

    always #5 clk = ~clk;

    // Accept edge, then apply a2/d2/keep and wait for Done; lat counts edges after accept.
    task automatic run_op(input logic [15:0] a, input logic d, input logic keep,
                          input logic [15:0] a2, input logic d2, output int lat, output int busy_n);
        Start = 1'b1; In = a; Dir = d;
        @(posedge clk); #1;
        Start = keep; In = a2; Dir = d2;
        lat = 0; busy_n = 0;
        while (!Done && lat < 20) begin
            if (Busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic d,
                                  output logic [15:0] o, output logic [3:0] c);
        o = a; c = 4'd0;
        if (a == 16'h0) begin c = 4'd15; return; end
        while (d ? !o[0] : !o[15]) begin
            o = d ? o >> 1 : o << 1;
            c++;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if ({Busy, Done, Out, Cnt, Zero} !== 23'h0) begin
            $display("FAIL reset: got busy=%b done=%b out=%h cnt=%0d zero=%b, want all zero", Busy, Done, Out, Cnt, Zero); miscompares++; end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bn;
        run_op(16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b1, lat, bn);
        vectors++; if (lat !== 4) begin $display("FAIL basic_latency: got %0d want 4", lat); miscompares++; end
        vectors++; if (bn !== 4) begin $display("FAIL basic_busy_cycles: got %0d want 4", bn); miscompares++; end
        vectors++; if (Out !== 16'h8000) begin $display("FAIL basic_out: got %h want 8000", Out); miscompares++; end
        vectors++; if (Cnt !== 4'd15) begin $display("FAIL basic_cnt: got %0d want 15", Cnt); miscompares++; end
        vectors++; if (Zero !== 1'b0) begin $display("FAIL basic_zero: got %b want 0", Zero); miscompares++; end
        @(posedge clk); #1;
        vectors++; if (Done !== 1'b0) begin $display("FAIL basic_done_pulse: got %b want 0", Done); miscompares++; end
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (Out !== 16'h8000 || Cnt !== 4'd15) begin
            $display("FAIL basic_hold: got out=%h cnt=%0d want 8000/15", Out, Cnt); miscompares++; end
    endtask

    task automatic test_justify();
        logic [15:0] ti [6] = '{16'h00F0, 16'h00F0, 16'h8000, 16'h0000, 16'h0000, 16'h0001};
        logic        td [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] to [6] = '{16'hF000, 16'h000F, 16'h8000, 16'h0000, 16'h0000, 16'h0001};
        logic [3:0]  tc [6] = '{4'd8, 4'd4, 4'd0, 4'd15, 4'd15, 4'd0};
        logic        tz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, bn;
        for (int i = 0; i < 6; i++) begin
            run_op(ti[i], td[i], 1'b0, ~ti[i], ~td[i], lat, bn);
            vectors++; if (lat !== 4 || Out !== to[i] || Cnt !== tc[i] || Zero !== tz[i]) begin
                $display("FAIL justify[%0d] in=%h dir=%b: got lat=%0d out=%h cnt=%0d zero=%b want lat=4 out=%h cnt=%0d zero=%b",
                         i, ti[i], td[i], lat, Out, Cnt, Zero, to[i], tc[i], tz[i]); miscompares++; end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(16'h0010, 1'b0, 1'b1, 16'hFFFF, 1'b1, lat, bn);
        vectors++; if (lat !== 4 || Out !== 16'h8000 || Cnt !== 4'd11) begin
            $display("FAIL ignore_busy_start: got lat=%0d out=%h cnt=%0d want 4/8000/11", lat, Out, Cnt); miscompares++; end
        run_op(16'hFFFF, 1'b1, 1'b0, 16'h0, 1'b0, lat, bn);
        vectors++; if (lat !== 4 || bn !== 4) begin
            $display("FAIL back_to_back_timing: got lat=%0d busy=%0d want 4/4", lat, bn); miscompares++; end
        vectors++; if (Out !== 16'hFFFF || Cnt !== 4'd0 || Zero !== 1'b0) begin
            $display("FAIL back_to_back_result: got out=%h cnt=%0d zero=%b want ffff/0/0", Out, Cnt, Zero); miscompares++; end
    endtask

    task automatic test_reset_mid();
        int lat, bn, dones = 0;
        Start = 1'b1; In = 16'h0003; Dir = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vectors++; if ({Busy, Done, Out, Cnt, Zero} !== 23'h0) begin
            $display("FAIL reset_mid: got busy=%b done=%b out=%h cnt=%0d zero=%b, want all zero", Busy, Done, Out, Cnt, Zero); miscompares++; end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        vectors++; if (dones !== 0) begin $display("FAIL reset_mid_no_done: got %0d pulses want 0", dones); miscompares++; end
        run_op(16'h0300, 1'b1, 1'b0, 16'h0, 1'b0, lat, bn);
        vectors++; if (lat !== 4 || Out !== 16'h0003 || Cnt !== 4'd8) begin
            $display("FAIL after_reset_op: got lat=%0d out=%h cnt=%0d want 4/0003/8", lat, Out, Cnt); miscompares++; end
    endtask

    task automatic test_random();
        int lat, bn;
        logic [15:0] a, eo;
        logic [3:0] ec;
        logic d;
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            a = i[0] ? a >> $urandom_range(0, 15) : a << $urandom_range(0, 15);
            if (i % 97 == 0) a = 16'h0;
            d = i[1];
            model(a, d, eo, ec);
            run_op(a, d, 1'b0, ~a, ~d, lat, bn);
            vectors++; if (lat !== 4 || Out !== eo || Cnt !== ec || Zero !== (a == 16'h0)) begin
                $display("FAIL sweep in=%h dir=%b: got lat=%0d out=%h cnt=%0d zero=%b want 4/%h/%0d/%b",
                         a, d, lat, Out, Cnt, Zero, eo, ec, a == 16'h0); miscompares++; end
            if (a != 16'h0) begin
                vectors++; if ((d ? Out << Cnt : Out >> Cnt) !== a || (d ? !Out[0] : !Out[15])) begin
                    $display("FAIL roundtrip in=%h dir=%b: out=%h cnt=%0d", a, d, Out, Cnt); miscompares++; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_justify();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
